// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM11 duty sequencer.
package pwm_pkg;

    localparam int PWM_DUTY_W   = 11;
    localparam int PWM_STEP_W   = 6;
    localparam int PWM_OC_LIMIT = 4;
    localparam int PWM_OC_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STOP  = 2'd2,
        ST_FAULT = 2'd3
    } seq_state_t;

endpackage

// File: rtl/duty_slew_step.sv
// One slew step of duty toward a target: saturating, never overshoots, and can
// be blocked from increasing while an overcurrent was seen in the period.
module duty_slew_step #(
    parameter int DUTY_W = 11,
    parameter int STEP_W = 6
) (
    input  logic [DUTY_W-1:0] i_cur,
    input  logic [DUTY_W-1:0] i_tgt,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_inhibit_up,
    output logic [DUTY_W-1:0] o_next
);

    logic [STEP_W-1:0] w_step_nz;
    logic [DUTY_W-1:0] w_step_ext;
    logic [DUTY_W-1:0] w_up_diff;
    logic [DUTY_W-1:0] w_dn_diff;

    // A zero step would stall the ramp forever, so it behaves as one LSB.
    assign w_step_nz  = (i_step == '0) ? STEP_W'(1) : i_step;
    assign w_step_ext = DUTY_W'(w_step_nz);
    assign w_up_diff  = i_tgt - i_cur;
    assign w_dn_diff  = i_cur - i_tgt;

    always_comb begin
        o_next = i_cur;
        if (i_tgt > i_cur) begin
            if (!i_inhibit_up) begin
                o_next = (w_up_diff > w_step_ext) ? (i_cur + w_step_ext) : i_tgt;
            end
        end else if (i_tgt < i_cur) begin
            o_next = (w_dn_diff > w_step_ext) ? (i_cur - w_step_ext) : i_tgt;
        end
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Soft-start / slew-limited duty sequencer for PWM11 with a cycle-by-cycle
// overcurrent counter that latches FAULT after OC_LIMIT consecutive periods.
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int DUTY_W   = PWM_DUTY_W,
    parameter int STEP_W   = PWM_STEP_W,
    parameter int OC_LIMIT = PWM_OC_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_target,
    input  logic [STEP_W-1:0] step,
    input  logic              PWM_synch,
    input  logic              OVR_I,
    input  logic              OVR_I_blank_n,
    input  logic              clr_fault,
    output logic [DUTY_W-1:0] duty,
    output logic              at_target,
    output logic              fault
);

    seq_state_t              r_state;
    logic [DUTY_W-1:0]       r_duty;
    logic                    r_at_target;
    logic                    r_fault;
    logic                    r_oc_seen;
    logic [PWM_OC_CNT_W-1:0] r_oc_cnt;

    logic [DUTY_W-1:0]       w_slew_tgt;
    logic [DUTY_W-1:0]       w_next_duty;
    logic                    w_oc_valid;
    logic [PWM_OC_CNT_W-1:0] w_oc_cnt_inc;
    logic                    w_oc_trip;

    // With enable low the ramp heads to zero, which is the STOP decrement.
    assign w_slew_tgt   = enable ? duty_target : '0;
    assign w_oc_valid   = OVR_I & OVR_I_blank_n;
    assign w_oc_cnt_inc = r_oc_cnt + PWM_OC_CNT_W'(1);
    assign w_oc_trip    = r_oc_seen && (w_oc_cnt_inc == PWM_OC_CNT_W'(OC_LIMIT));

    duty_slew_step #(
        .DUTY_W (DUTY_W),
        .STEP_W (STEP_W)
    ) u_slew (
        .i_cur        (r_duty),
        .i_tgt        (w_slew_tgt),
        .i_step       (step),
        .i_inhibit_up (r_oc_seen),
        .o_next       (w_next_duty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_duty      <= '0;
            r_at_target <= 1'b0;
            r_fault     <= 1'b0;
            r_oc_seen   <= 1'b0;
            r_oc_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_duty      <= '0;
                    r_oc_seen   <= 1'b0;
                    r_oc_cnt    <= '0;
                    r_fault     <= 1'b0;
                    r_at_target <= 1'b0;
                    if (enable) begin
                        r_state     <= ST_RUN;
                        r_at_target <= (duty_target == '0);
                    end
                end
                ST_RUN, ST_STOP: begin
                    if (PWM_synch) begin
                        if (w_oc_trip) begin
                            // Fault entry wins over both the duty update and enable.
                            r_state     <= ST_FAULT;
                            r_fault     <= 1'b1;
                            r_at_target <= 1'b0;
                            r_oc_seen   <= 1'b0;
                            r_oc_cnt    <= '0;
                        end else begin
                            r_duty    <= w_next_duty;
                            r_oc_cnt  <= r_oc_seen ? w_oc_cnt_inc : '0;
                            r_oc_seen <= w_oc_valid;
                            if (enable) begin
                                r_state     <= ST_RUN;
                                r_at_target <= (w_next_duty == duty_target);
                            end else begin
                                r_at_target <= 1'b0;
                                r_state     <= (w_next_duty == '0) ? ST_IDLE : ST_STOP;
                            end
                        end
                    end else begin
                        r_oc_seen <= r_oc_seen | w_oc_valid;
                        if (enable) begin
                            r_state     <= ST_RUN;
                            r_at_target <= (r_duty == duty_target);
                        end else begin
                            r_at_target <= 1'b0;
                            r_state     <= (r_duty == '0) ? ST_IDLE : ST_STOP;
                        end
                    end
                end
                ST_FAULT: begin
                    r_duty      <= '0;
                    r_at_target <= 1'b0;
                    r_oc_seen   <= 1'b0;
                    r_oc_cnt    <= '0;
                    if (clr_fault && !enable) begin
                        r_state <= ST_IDLE;
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign duty      = r_duty;
    assign at_target = r_at_target;
    assign fault     = r_fault;

endmodule
